// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the upstream table/message FSMs and the UART transmitter.
interface uart_tx_serializer_if;
  logic [7:0] txdata;
  logic       ldtxdata;
  logic       txempty;

  modport master (output txdata, output ldtxdata, input txempty);
  modport slave  (input txdata, input ldtxdata, output txempty);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter, LSB first, with a one-byte holding register so the
// upstream FSM can queue the next character and frames go out back-to-back.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_serializer_if.slave  up,
  output logic                 tx,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    hold_data;
  logic          hold_full, hold_full_nxt;
  logic          overrun_nxt;
  logic          tx_nxt, busy_nxt;
  logic          wrap, transfer, load_ok;

  // State register plus registered outputs; only control state is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      hold_full <= hold_full_nxt;
      overrun   <= overrun_nxt;
      tx        <= tx_nxt;
      busy      <= busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
    if (load_ok) hold_data <= up.txdata;
  end

  // Next-state: bit timing, shifting and the hold-to-shift transfer.
  always_comb begin
    wrap      = (cnt == CNT_LAST);
    transfer  = hold_full && ((state == IDLE) || ((state == STOP) && wrap));
    load_ok   = up.ldtxdata && !hold_full;
    state_nxt = state;
    cnt_nxt   = wrap ? '0 : cnt + 1'b1;
    idx_nxt   = idx;
    shift_nxt = shift;
    case (state)
      IDLE:  cnt_nxt = '0;
      START: begin
        if (wrap) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (wrap) begin
          shift_nxt = {1'b0, shift[7:1]};
          idx_nxt   = idx + 1'b1;
          if (idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP:    if (wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (transfer) begin
      shift_nxt = hold_data;
      state_nxt = START;
      cnt_nxt   = '0;
    end
    // A load against a full holding register is dropped even if it empties this edge.
    hold_full_nxt = load_ok | (hold_full & ~transfer);
    overrun_nxt   = overrun | (up.ldtxdata & hold_full);
  end

  // Output decode from the next state so tx and busy come straight from flops.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign up.txempty = ~hold_full;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a timing-level line model predicts
// each frame's byte and start edge; a line monitor decodes frames and compares.
module tb_uart_tx_serializer;
  localparam int NI = 2;

  typedef struct packed {
    logic [7:0] b;
    int         start;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic       rst [NI];
  logic       ld  [NI];
  logic [7:0] dat [NI];
  logic       tx0, tx1, busy0, busy1, ovr0, ovr1;

  uart_tx_serializer_if if0 ();
  uart_tx_serializer_if if1 ();
  assign if0.ldtxdata = ld[0];
  assign if0.txdata   = dat[0];
  assign if1.ldtxdata = ld[1];
  assign if1.txdata   = dat[1];

  uart_tx_serializer #(.CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .reset(rst[0]), .up(if0), .tx(tx0), .busy(busy0), .overrun(ovr0)
  );
  uart_tx_serializer #(.CLKS_PER_BIT(2)) dut1 (
    .clk(clk), .reset(rst[1]), .up(if1), .tx(tx1), .busy(busy1), .overrun(ovr1)
  );

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   line_free [NI];
  int   hold_rel  [NI];
  logic ovr_exp   [NI];

  logic       in_fr    [NI];
  int         cyc      [NI];
  int         fstart   [NI];
  logic [9:0] fbits    [NI];
  logic       shape_ok [NI];
  int         idle_bad [NI];

  function automatic int cpb(input int i);
    return (i == 0) ? 4 : 2;
  endfunction
  function automatic logic get_tx(input int i);
    return (i == 0) ? tx0 : tx1;
  endfunction
  function automatic logic get_busy(input int i);
    return (i == 0) ? busy0 : busy1;
  endfunction
  function automatic logic get_ovr(input int i);
    return (i == 0) ? ovr0 : ovr1;
  endfunction
  function automatic logic get_txe(input int i);
    return (i == 0) ? if0.txempty : if1.txempty;
  endfunction
  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    if (i == 0) q0.delete(); else q1.delete();
    line_free[i] = 0;
    hold_rel[i]  = -1;
    ovr_exp[i]   = 1'b0;
  endtask

  task automatic push_exp(input int i, input logic [7:0] b, input int s);
    exp_t e;
    e.b = b;
    e.start = s;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Strobe ldtxdata for one edge; the model decides accept/overrun and the start edge.
  task automatic load(input int i, input logic [7:0] b, output int s);
    int n;
    @(negedge clk);
    ld[i]  = 1'b1;
    dat[i] = b;
    n = edge_n + 1;
    if (n <= hold_rel[i]) begin
      ovr_exp[i] = 1'b1;
      s = -1;
    end else begin
      s = (n + 1 > line_free[i]) ? n + 1 : line_free[i];
      hold_rel[i]  = s;
      line_free[i] = s + 10 * cpb(i);
      push_exp(i, b, s);
    end
    @(negedge clk);
    ld[i]  = 1'b0;
    dat[i] = 8'($urandom);
    if (s >= 0) chk($sformatf("txempty_after_load%0d", i), int'(get_txe(i)), 0);
  endtask

  // Upstream protocol: poll txempty, strobe, wait a cycle.
  task automatic send(input int i, input logic [7:0] b);
    int k;
    int s;
    k = 0;
    while (get_txe(i) !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk($sformatf("poll_timeout%0d", i), k, 0);
    load(i, b, s);
  endtask

  task automatic wait_done(input int i);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (qsize(i) == 0 && get_busy(i) == 1'b0 && get_txe(i) == 1'b1) done = 1'b1;
    end
    chk($sformatf("drain%0d", i), int'(done), 1);
  endtask

  task automatic finish_frame(input int i);
    exp_t e;
    if (qsize(i) == 0) begin
      chk($sformatf("unexpected_frame%0d_byte%02h", i, fbits[i][8:1]), 1, 0);
    end else begin
      if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
      chk($sformatf("frame_byte%0d", i), int'(fbits[i][8:1]), int'(e.b));
      chk($sformatf("frame_start_edge%0d", i), fstart[i], e.start);
      chk($sformatf("frame_shape%0d", i),
          int'(shape_ok[i] && fbits[i][0] == 1'b0 && fbits[i][9] == 1'b1), 1);
    end
    in_fr[i] = 1'b0;
  endtask

  task automatic mon_step(input int i, input logic t, input logic b);
    int c;
    int p;
    c = cpb(i);
    if (rst[i]) begin
      in_fr[i] = 1'b0;
      return;
    end
    if (!in_fr[i]) begin
      if (t == 1'b0) begin
        in_fr[i]    = 1'b1;
        cyc[i]      = 0;
        fstart[i]   = edge_n;
        fbits[i]    = 10'h0;
        shape_ok[i] = b;
      end else if (b != 1'b0) begin
        idle_bad[i]++;
      end
      return;
    end
    cyc[i]++;
    p = cyc[i] / c;
    if (cyc[i] % c == 0) fbits[i][p] = t;
    else if (t != fbits[i][p]) shape_ok[i] = 1'b0;
    if (b != 1'b1) shape_ok[i] = 1'b0;
    if (cyc[i] == 10 * c - 1) finish_frame(i);
  endtask

  always @(negedge clk) begin
    mon_step(0, tx0, busy0);
    mon_step(1, tx1, busy1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int s;
    int bad;
    int n;
    logic stopped;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1;
      ld[i]  = 1'b0;
      dat[i] = 8'h00;
      in_fr[i] = 1'b0;
      idle_bad[i] = 0;
      model_reset(i);
    end

    // Reset and idle line.
    @(negedge clk);
    chk("reset_tx", int'(tx0), 1);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_txempty", int'(if0.txempty), 1);
    chk("reset_overrun", int'(ovr1), 0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++)
        if (get_tx(i) !== 1'b1 || get_txe(i) !== 1'b1 || get_busy(i) !== 1'b0 || get_ovr(i) !== 1'b0)
          bad++;
    end
    chk("idle_after_reset", bad, 0);

    // Single byte 't' on an idle line.
    load(0, 8'h74, s);
    @(negedge clk);
    chk("single_txempty_back_high", int'(if0.txempty), 1);
    chk("single_tx_start", int'(tx0), 0);
    n = 0;
    stopped = 1'b0;
    for (int k = 0; k < 100 && !stopped; k++) begin
      if (busy0) begin
        n++;
        @(negedge clk);
      end else begin
        stopped = 1'b1;
      end
    end
    chk("single_busy_cycles", n, 40);
    wait_done(0);

    // Back-to-back upstream message.
    send(0, 8'h74); send(0, 8'h5B); send(0, 8'h30); send(0, 8'h31);
    send(0, 8'h5D); send(0, 8'h3D); send(0, 8'h22);
    wait_done(0);
    chk("b2b_overrun", int'(ovr0), 0);

    // Overrun: third load arrives while 0x42 is still held.
    load(0, 8'h41, s);
    load(0, 8'h42, s);
    load(0, 8'h43, s);
    chk("overrun_dropped", s, -1);
    wait_done(0);
    chk("overrun_flag", int'(ovr0), int'(ovr_exp[0]));

    // Reset mid-frame during data bit 3 of 0x5B with 0x30 held.
    @(negedge clk);
    rst[0] = 1'b1;
    model_reset(0);
    @(negedge clk);
    rst[0] = 1'b0;
    load(0, 8'h5B, s);
    load(0, 8'h30, n);
    for (int k = 0; k < 200 && edge_n < s + 4 * 4 + 1; k++) @(negedge clk);
    #1;
    rst[0] = 1'b1;
    model_reset(0);
    #1;
    chk("midreset_tx", int'(tx0), 1);
    chk("midreset_busy", int'(busy0), 0);
    chk("midreset_txempty", int'(if0.txempty), 1);
    chk("midreset_overrun", int'(ovr0), 0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    repeat (60) @(negedge clk);
    load(0, 8'h2D, s);
    wait_done(0);

    // Boundary: two cycles per bit, all-ones then all-zeros.
    load(1, 8'hFF, s);
    load(1, 8'h00, s);
    wait_done(1);

    // Randomized traffic on both instances, including occasional blind loads.
    for (int r = 0; r < 24; r++) begin
      int i;
      i = r % NI;
      repeat ($urandom_range(0, 25)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) load(i, 8'($urandom), s);
      else send(i, 8'($urandom));
    end
    wait_done(0);
    wait_done(1);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("final_overrun%0d", i), int'(get_ovr(i)), int'(ovr_exp[i]));
      chk($sformatf("idle_busy%0d", i), idle_bad[i], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
